// File: rtl/register_file_multiport.sv
`default_nettype none
// ============================================================================
// Module      : register_file_multiport
// Description : Parametrised multi-write / multi-read register bank with
//               fixed highest-port-wins write priority, optional hardwired
//               zero register, combinational or registered reads with
//               optional write-to-read forwarding, and a registered write
//               collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_multiport #(
  parameter int M          = 32,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NW         = 2,
  parameter int NR         = 2,
  parameter int SYNC_READ  = 0,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic                     en,
  input  logic [NW-1:0]            we,
  input  logic [NW*ADDR_WIDTH-1:0] waddr,
  input  logic [NW*WIDTH-1:0]      wdata,
  input  logic [NR-1:0]            re,
  input  logic [NR*ADDR_WIDTH-1:0] raddr,
  output logic [NR*WIDTH-1:0]      rdata,
  output logic                     wcollision
);

  // One extra bit so that M == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] M_LIM = (ADDR_WIDTH+1)'(M);

  // Storage
  logic [WIDTH-1:0]      mem [M];

  // Unpacked views of the packed port buses
  logic [ADDR_WIDTH-1:0] wa [NW];
  logic [WIDTH-1:0]      wd [NW];
  logic [ADDR_WIDTH-1:0] ra [NR];

  // Per write port: address in range, and write actually lands in the array
  logic [NW-1:0]         w_in_range;
  logic [NW-1:0]         w_commit;

  // Per register: some port writes it this edge, and the winning data
  logic [M-1:0]          hit;
  logic [WIDTH-1:0]      hit_val [M];

  // Per read port: current array value, and value to capture in sync mode
  logic [WIDTH-1:0]      rd_arr  [NR];
  logic [WIDTH-1:0]      rd_next [NR];

  logic                  collision;

  genvar gk, gj;

  generate
    for (gk = 0; gk < NW; gk++) begin : g_wunpack
      assign wa[gk] = waddr[gk*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[gk] = wdata[gk*WIDTH +: WIDTH];
    end
    for (gj = 0; gj < NR; gj++) begin : g_runpack
      assign ra[gj] = raddr[gj*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Qualify each write port: gated by ce/en/we, in range, and not aimed at
  // a hardwired-zero register 0.
  always_comb begin
    w_in_range = '0;
    w_commit   = '0;
    for (int k = 0; k < NW; k++) begin
      w_in_range[k] = ({1'b0, wa[k]} < M_LIM);
      w_commit[k]   = ce && en && we[k] && w_in_range[k] &&
                      !((ZERO_REG != 0) && (wa[k] == '0));
    end
  end

  // Resolve writes per register; iterating ports upward lets the
  // highest-indexed port override lower ones on a shared address.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      hit[i]     = 1'b0;
      hit_val[i] = '0;
      for (int k = 0; k < NW; k++) begin
        if (w_commit[k] && (wa[k] == ADDR_WIDTH'(i))) begin
          hit[i]     = 1'b1;
          hit_val[i] = wd[k];
        end
      end
    end
  end

  // Register array update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < M; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        if (hit[i]) begin
          mem[i] <= hit_val[i];
        end
      end
    end
  end

  // Collision detect: any two enabled ports on the same in-range address.
  // Independent of ce here; ce only decides whether the flag is updated.
  always_comb begin
    collision = 1'b0;
    for (int k = 0; k < NW; k++) begin
      for (int l = k + 1; l < NW; l++) begin
        if (en && we[k] && we[l] && w_in_range[k] && w_in_range[l] &&
            (wa[k] == wa[l])) begin
          collision = 1'b1;
        end
      end
    end
  end

  // Registered collision flag, frozen while ce is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcollision <= 1'b0;
    end else if (ce) begin
      wcollision <= collision;
    end
  end

  // Array read per port with an explicit mux so out-of-range addresses
  // fall through to zero; register 0 forced to zero when hardwired.
  always_comb begin
    for (int j = 0; j < NR; j++) begin
      rd_arr[j] = '0;
      for (int i = 0; i < M; i++) begin
        if (ra[j] == ADDR_WIDTH'(i)) begin
          rd_arr[j] = mem[i];
        end
      end
      if ((ZERO_REG != 0) && (ra[j] == '0)) begin
        rd_arr[j] = '0;
      end
    end
  end

  // Capture value for registered reads: optionally forward the winning
  // same-edge write data. w_commit already excludes register 0 when it is
  // hardwired and out-of-range addresses, so forwarding cannot leak them.
  always_comb begin
    for (int j = 0; j < NR; j++) begin
      rd_next[j] = rd_arr[j];
      if (BYPASS != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (w_commit[k] && (wa[k] == ra[j])) begin
            rd_next[j] = wd[k];
          end
        end
      end
    end
  end

  generate
    if (SYNC_READ != 0) begin : g_sync_read
      logic [WIDTH-1:0] rd_q [NR];

      // Read registers, updated only on ce with the per-port enable.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int j = 0; j < NR; j++) begin
            rd_q[j] <= '0;
          end
        end else if (ce) begin
          for (int j = 0; j < NR; j++) begin
            if (re[j]) begin
              rd_q[j] <= rd_next[j];
            end
          end
        end
      end

      for (gj = 0; gj < NR; gj++) begin : g_rd_out
        assign rdata[gj*WIDTH +: WIDTH] = rd_q[gj];
      end
    end else begin : g_async_read
      // Read enables and forwarding have no role in combinational mode.
      logic             unused_re;
      logic [WIDTH-1:0] unused_next;
      assign unused_re = ^re;

      always_comb begin
        unused_next = '0;
        for (int j = 0; j < NR; j++) begin
          unused_next = unused_next ^ rd_next[j];
        end
      end

      for (gj = 0; gj < NR; gj++) begin : g_rd_out
        assign rdata[gj*WIDTH +: WIDTH] = rd_arr[gj];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_register_file_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_multiport
// Description : Directed bench for register_file_multiport. Four instances
//               share stimulus: A = async default, B = sync + bypass + zero
//               register, C = sync without bypass, D = async with M = 20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_multiport;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        en;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [15:0] rdata_a, rdata_b, rdata_c, rdata_d;
  logic        wcol_a, wcol_b, wcol_c, wcol_d;

  int checks = 0;
  int errors = 0;

  register_file_multiport #(.SYNC_READ(0), .BYPASS(1), .ZERO_REG(0)) u_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .en(en), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_a), .wcollision(wcol_a));

  register_file_multiport #(.SYNC_READ(1), .BYPASS(1), .ZERO_REG(1)) u_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .en(en), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_b), .wcollision(wcol_b));

  register_file_multiport #(.SYNC_READ(1), .BYPASS(0), .ZERO_REG(0)) u_c (
    .clk(clk), .reset_n(reset_n), .ce(ce), .en(en), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_c), .wcollision(wcol_c));

  register_file_multiport #(.M(20), .SYNC_READ(0)) u_d (
    .clk(clk), .reset_n(reset_n), .ce(ce), .en(en), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_d), .wcollision(wcol_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_write(input logic [1:0] w, input logic [4:0] a0,
                           input logic [7:0] d0, input logic [4:0] a1,
                           input logic [7:0] d1);
    we    = w;
    waddr = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic set_read(input logic [1:0] r, input logic [4:0] a0,
                          input logic [4:0] a1);
    re    = r;
    raddr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ce = 1'b1;
    en = 1'b1;
    set_write(2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
    set_read(2'b00, 5'd0, 5'd0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rdata_a[7:0] !== 8'h00) begin errors++; $display("FAIL rst_init_a got %h exp 00", rdata_a[7:0]); end
    checks++; if (rdata_b[7:0] !== 8'h00) begin errors++; $display("FAIL rst_init_b got %h exp 00", rdata_b[7:0]); end
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL rst_init_wcol got %b exp 0", wcol_a); end
    set_write(2'b01, 5'd3, 8'hA5, 5'd0, 8'h00);
    set_read(2'b01, 5'd3, 5'd0);
    tick();
    set_write(2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
    tick();
    checks++; if (rdata_a[7:0] !== 8'hA5) begin errors++; $display("FAIL rst_pre_a got %h exp a5", rdata_a[7:0]); end
    checks++; if (rdata_b[7:0] !== 8'hA5) begin errors++; $display("FAIL rst_pre_b got %h exp a5", rdata_b[7:0]); end
    checks++; if (rdata_c[7:0] !== 8'hA5) begin errors++; $display("FAIL rst_pre_c got %h exp a5", rdata_c[7:0]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rdata_a[7:0] !== 8'h00) begin errors++; $display("FAIL rst_async_a got %h exp 00", rdata_a[7:0]); end
    checks++; if (rdata_b[7:0] !== 8'h00) begin errors++; $display("FAIL rst_async_b got %h exp 00", rdata_b[7:0]); end
    checks++; if (rdata_c[7:0] !== 8'h00) begin errors++; $display("FAIL rst_async_c got %h exp 00", rdata_c[7:0]); end
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL rst_async_wcol got %b exp 0", wcol_a); end
    reset_n = 1'b1;
  endtask

  task automatic test_parallel();
    do_reset();
    set_write(2'b11, 5'd4, 8'h11, 5'd9, 8'h22);
    tick();
    set_write(2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
    set_read(2'b00, 5'd4, 5'd9);
    #1;
    checks++; if (rdata_a !== 16'h2211) begin errors++; $display("FAIL par_a got %h exp 2211", rdata_a); end
    checks++; if (rdata_d !== 16'h2211) begin errors++; $display("FAIL par_d got %h exp 2211", rdata_d); end
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL par_wcol got %b exp 0", wcol_a); end
  endtask

  task automatic test_collision();
    do_reset();
    set_write(2'b11, 5'd7, 8'h33, 5'd7, 8'h44);
    set_read(2'b01, 5'd7, 5'd8);
    #1;
    checks++; if (rdata_a[7:0] !== 8'h00) begin errors++; $display("FAIL col_prewrite got %h exp 00", rdata_a[7:0]); end
    tick();
    checks++; if (wcol_a !== 1'b1) begin errors++; $display("FAIL col_flag_a got %b exp 1", wcol_a); end
    checks++; if (wcol_b !== 1'b1) begin errors++; $display("FAIL col_flag_b got %b exp 1", wcol_b); end
    checks++; if (rdata_b[7:0] !== 8'h44) begin errors++; $display("FAIL col_bypass_b got %h exp 44", rdata_b[7:0]); end
    checks++; if (rdata_c[7:0] !== 8'h00) begin errors++; $display("FAIL col_old_c got %h exp 00", rdata_c[7:0]); end
    set_write(2'b01, 5'd8, 8'h66, 5'd0, 8'h00);
    tick();
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL col_clear got %b exp 0", wcol_a); end
    checks++; if (rdata_c[7:0] !== 8'h44) begin errors++; $display("FAIL col_late_c got %h exp 44", rdata_c[7:0]); end
    checks++; if (rdata_a !== 16'h6644) begin errors++; $display("FAIL col_array_a got %h exp 6644", rdata_a); end
  endtask

  task automatic test_sync_bypass();
    do_reset();
    set_write(2'b01, 5'd5, 8'h10, 5'd0, 8'h00);
    tick();
    set_write(2'b01, 5'd5, 8'h55, 5'd0, 8'h00);
    set_read(2'b01, 5'd5, 5'd0);
    tick();
    checks++; if (rdata_b[7:0] !== 8'h55) begin errors++; $display("FAIL byp_on got %h exp 55", rdata_b[7:0]); end
    checks++; if (rdata_c[7:0] !== 8'h10) begin errors++; $display("FAIL byp_off got %h exp 10", rdata_c[7:0]); end
    set_write(2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
    tick();
    checks++; if (rdata_c[7:0] !== 8'h55) begin errors++; $display("FAIL byp_off_next got %h exp 55", rdata_c[7:0]); end
    set_write(2'b01, 5'd5, 8'h5A, 5'd0, 8'h00);
    set_read(2'b00, 5'd5, 5'd0);
    tick();
    checks++; if (rdata_b[7:0] !== 8'h55) begin errors++; $display("FAIL re_hold_b got %h exp 55", rdata_b[7:0]); end
    checks++; if (rdata_c[7:0] !== 8'h55) begin errors++; $display("FAIL re_hold_c got %h exp 55", rdata_c[7:0]); end
    checks++; if (rdata_a[7:0] !== 8'h5A) begin errors++; $display("FAIL re_async_a got %h exp 5a", rdata_a[7:0]); end
  endtask

  task automatic test_gating_zero();
    do_reset();
    set_write(2'b11, 5'd0, 8'hFF, 5'd2, 8'h21);
    set_read(2'b11, 5'd0, 5'd2);
    tick();
    checks++; if (rdata_b !== 16'h2100) begin errors++; $display("FAIL zero_b got %h exp 2100", rdata_b); end
    checks++; if (rdata_a !== 16'h21FF) begin errors++; $display("FAIL nozero_a got %h exp 21ff", rdata_a); end
    ce = 1'b0;
    set_write(2'b11, 5'd2, 8'h77, 5'd2, 8'h78);
    set_read(2'b11, 5'd2, 5'd2);
    tick();
    checks++; if (rdata_b !== 16'h2100) begin errors++; $display("FAIL ce_hold_b got %h exp 2100", rdata_b); end
    checks++; if (rdata_a !== 16'h2121) begin errors++; $display("FAIL ce_nowrite_a got %h exp 2121", rdata_a); end
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL ce_wcol got %b exp 0", wcol_a); end
    ce = 1'b1;
    en = 1'b0;
    tick();
    checks++; if (rdata_a !== 16'h2121) begin errors++; $display("FAIL en_nowrite_a got %h exp 2121", rdata_a); end
    checks++; if (rdata_b !== 16'h2121) begin errors++; $display("FAIL en_read_b got %h exp 2121", rdata_b); end
    checks++; if (wcol_a !== 1'b0) begin errors++; $display("FAIL en_wcol got %b exp 0", wcol_a); end
    en = 1'b1;
  endtask

  task automatic test_range();
    do_reset();
    set_write(2'b01, 5'd25, 8'h99, 5'd0, 8'h00);
    set_read(2'b00, 5'd25, 5'd25);
    tick();
    checks++; if (rdata_d[7:0] !== 8'h00) begin errors++; $display("FAIL rng_read_d got %h exp 00", rdata_d[7:0]); end
    checks++; if (rdata_a[7:0] !== 8'h99) begin errors++; $display("FAIL rng_read_a got %h exp 99", rdata_a[7:0]); end
    set_read(2'b00, 5'd9, 5'd5);
    #1;
    checks++; if (rdata_d !== 16'h0000) begin errors++; $display("FAIL rng_alias_d got %h exp 0000", rdata_d); end
    set_write(2'b11, 5'd25, 8'h99, 5'd25, 8'h98);
    tick();
    checks++; if (wcol_a !== 1'b1) begin errors++; $display("FAIL rng_wcol_a got %b exp 1", wcol_a); end
    checks++; if (wcol_d !== 1'b0) begin errors++; $display("FAIL rng_wcol_d got %b exp 0", wcol_d); end
    set_write(2'b01, 5'd19, 8'hC3, 5'd0, 8'h00);
    set_read(2'b00, 5'd19, 5'd25);
    tick();
    checks++; if (rdata_d !== 16'h00C3) begin errors++; $display("FAIL rng_last_d got %h exp 00c3", rdata_d); end
    checks++; if (rdata_a !== 16'h98C3) begin errors++; $display("FAIL rng_last_a got %h exp 98c3", rdata_a); end
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    en      = 1'b0;
    we      = '0;
    waddr   = '0;
    wdata   = '0;
    re      = '0;
    raddr   = '0;
    test_reset();
    test_parallel();
    test_collision();
    test_sync_bypass();
    test_gating_zero();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
